// File: rtl/register_bank_pkg.sv
// Shared cpu constants for the RiskOW register file, decoder and ALU.
package register_bank_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 16;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

endpackage

// File: rtl/register_bank_if.sv
// Single shared read/write port of the RiskOW register file.
interface register_bank_if;
    import register_bank_pkg::*;

    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic [ADDR_WIDTH-1:0] regNum;
    logic                  writeEnable;

    modport master (
        output dataIn,
        output regNum,
        output writeEnable,
        input  dataOut
    );

    modport slave (
        input  dataIn,
        input  regNum,
        input  writeEnable,
        output dataOut
    );

endinterface

// File: rtl/register_bank.sv
// 16 x 32-bit register file, one write or one registered read per clock.
module register_bank
    import register_bank_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    register_bank_if.slave bus
);

    logic [DATA_WIDTH-1:0] registers [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic                  w_is_x0;

    assign w_is_x0 = (bus.regNum == '0);

    // Entry 0 is only ever cleared, which keeps x0 reading as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registers[i] <= '0;
            end
            r_dataOut <= '0;
        end else if (bus.writeEnable) begin
            if (!w_is_x0) begin
                registers[bus.regNum] <= bus.dataIn;
            end
        end else begin
            r_dataOut <= w_is_x0 ? '0 : registers[bus.regNum];
        end
    end

    assign bus.dataOut = r_dataOut;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: reset, walk write, readback, x0, hold, async reset.
module tb_register_bank;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    register_bank_if bus ();

    register_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic drive(input logic we, input logic [3:0] rn,
                         input logic [31:0] d);
        bus.writeEnable = we;
        bus.regNum      = rn;
        bus.dataIn      = d;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'd5, 32'hDEADBEEF);
        reset = 1'b0;
        tick();
        checks++;
        if (bus.dataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_dataOut: got %h expected %h", bus.dataOut, 32'h0);
        end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (dut.registers[j] !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h",
                         j, dut.registers[j], 32'h0);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_walk_readback();
        for (int i = 1; i < 16; i++) begin
            apply_reset();
            drive(1'b1, 4'(i), 32'hFFFFFFFF);
            tick();
            for (int j = 0; j < 16; j++) begin
                checks++;
                if (j == i) begin
                    if (dut.registers[j] !== 32'hFFFFFFFF) begin
                        errors++;
                        $display("FAIL walk%0d_reg%0d: got %h expected %h",
                                 i, j, dut.registers[j], 32'hFFFFFFFF);
                    end
                end else if (dut.registers[j] !== 32'h0) begin
                    errors++;
                    $display("FAIL walk%0d_reg%0d: got %h expected %h",
                             i, j, dut.registers[j], 32'h0);
                end
            end
            drive(1'b0, 4'(i), 32'hF0F0F0F0);
            tick();
            checks++;
            if (bus.dataOut !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL readback%0d_dataOut: got %h expected %h",
                         i, bus.dataOut, 32'hFFFFFFFF);
            end
            checks++;
            if (dut.registers[i] !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL readback%0d_reg: got %h expected %h",
                         i, dut.registers[i], 32'hFFFFFFFF);
            end
        end
    endtask

    task automatic test_x0();
        apply_reset();
        drive(1'b1, 4'd5, 32'hCAFEF00D);
        tick();
        drive(1'b0, 4'd5, 32'h0);
        tick();
        checks++;
        if (bus.dataOut !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL x0_pre_read: got %h expected %h", bus.dataOut, 32'hCAFEF00D);
        end
        drive(1'b1, 4'd0, 32'h12345678);
        tick();
        checks++;
        if (dut.registers[0] !== 32'h0) begin
            errors++;
            $display("FAIL x0_reg: got %h expected %h", dut.registers[0], 32'h0);
        end
        drive(1'b0, 4'd0, 32'h0);
        tick();
        checks++;
        if (bus.dataOut !== 32'h0) begin
            errors++;
            $display("FAIL x0_read: got %h expected %h", bus.dataOut, 32'h0);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 4'd3, 32'hA5A5A5A5);
        tick();
        drive(1'b1, 4'd7, 32'h0BADF00D);
        tick();
        drive(1'b0, 4'd3, 32'h0);
        tick();
        checks++;
        if (bus.dataOut !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL hold_read3: got %h expected %h", bus.dataOut, 32'hA5A5A5A5);
        end
        drive(1'b1, 4'd3, 32'h11111111);
        tick();
        checks++;
        if (bus.dataOut !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL hold_dataOut: got %h expected %h", bus.dataOut, 32'hA5A5A5A5);
        end
        checks++;
        if (dut.registers[3] !== 32'h11111111) begin
            errors++;
            $display("FAIL hold_reg3: got %h expected %h", dut.registers[3], 32'h11111111);
        end
        checks++;
        if (dut.registers[7] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL hold_reg7: got %h expected %h", dut.registers[7], 32'h0BADF00D);
        end
        drive(1'b0, 4'd7, 32'hFFFFFFFF);
        tick();
        checks++;
        if (bus.dataOut !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL back_to_back_read7: got %h expected %h",
                     bus.dataOut, 32'h0BADF00D);
        end
        drive(1'b0, 4'd3, 32'h0);
        tick();
        checks++;
        if (bus.dataOut !== 32'h11111111) begin
            errors++;
            $display("FAIL back_to_back_read3: got %h expected %h",
                     bus.dataOut, 32'h11111111);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'd9, 32'h99999999);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.dataOut !== 32'h0) begin
            errors++;
            $display("FAIL async_dataOut: got %h expected %h", bus.dataOut, 32'h0);
        end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (dut.registers[j] !== 32'h0) begin
                errors++;
                $display("FAIL async_reg%0d: got %h expected %h",
                         j, dut.registers[j], 32'h0);
            end
        end
        tick();
        checks++;
        if (dut.registers[9] !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_lost: got %h expected %h",
                     dut.registers[9], 32'h0);
        end
        reset = 1'b1;
        drive(1'b0, 4'd9, 32'h0);
        tick();
        checks++;
        if (bus.dataOut !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_read9: got %h expected %h", bus.dataOut, 32'h0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        drive(1'b0, 4'd0, 32'h0);
        #2;
        test_reset();
        test_walk_readback();
        test_x0();
        test_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
